// File: rtl/mux4_rr_sched_pkg.sv
// mux4_rr_sched_pkg: scheduler state encoding and a reusable round-robin pick function (req, ptr) -> winner index
package mux4_rr_sched_pkg;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    rr_pick = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + k[1:0];
      if (req[idx]) rr_pick = idx;
    end
  endfunction
endpackage

// File: rtl/mux4_rr_sched_mux4_1.sv
// mux4_rr_sched_mux4_1: DW-wide 4:1 mux built from 1-bit slices; d0..d3 and sel in, y out
module mux4_rr_sched_mux4_1 #(
  parameter int DW = 1
) (
  input  logic [DW-1:0] d0,
  input  logic [DW-1:0] d1,
  input  logic [DW-1:0] d2,
  input  logic [DW-1:0] d3,
  input  logic [1:0]    sel,
  output logic [DW-1:0] y
);
  for (genvar b = 0; b < DW; b++) begin : g_bit
    assign y[b] = sel[1] ? (sel[0] ? d3[b] : d2[b]) : (sel[0] ? d1[b] : d0[b]);
  end
endmodule

// File: rtl/mux4_rr_sched.sv
// mux4_rr_sched: round-robin burst scheduler for a shared 4:1 mux; req/din0..3/out_ready in, gnt/sel/ack/dout/dout_valid/busy out
module mux4_rr_sched
  import mux4_rr_sched_pkg::*;
#(
  parameter int DW        = 1,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    req,
  input  logic [DW-1:0] din0,
  input  logic [DW-1:0] din1,
  input  logic [DW-1:0] din2,
  input  logic [DW-1:0] din3,
  input  logic          out_ready,
  output logic [3:0]    gnt,
  output logic [1:0]    sel,
  output logic [3:0]    ack,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          busy
);
  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d, sel_q, sel_d;
  logic [3:0]    cnt_q, cnt_d, gnt_q, gnt_d;
  logic [DW-1:0] dout_q, dout_d, mux_y;
  logic          dout_valid_q, dout_valid_d, beat, last;
  mux4_rr_sched_mux4_1 #(.DW(DW)) u_mux4_1 (
    .d0(din0), .d1(din1), .d2(din2), .d3(din3), .sel(sel_q), .y(mux_y)
  );
  assign beat = (state_q == GRANT) && req[sel_q] && (!dout_valid_q || out_ready);
  // a dropped request ends the grant without a beat; otherwise the final beat ends it
  assign last = !req[sel_q] || (beat && cnt_q == 4'(MAX_BURST - 1));
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    sel_d        = sel_q;
    gnt_d        = gnt_q;
    cnt_d        = beat ? cnt_q + 4'd1 : cnt_q;
    dout_d       = beat ? mux_y : dout_q;
    dout_valid_d = beat || (dout_valid_q && !out_ready);
    if (state_q == IDLE) begin
      if (|req) begin
        sel_d   = rr_pick(req, ptr_q);
        gnt_d   = 4'b0001 << sel_d;
        cnt_d   = '0;
        state_d = GRANT;
      end
    end else if (last) begin
      state_d = IDLE;
      gnt_d   = '0;
      ptr_d   = sel_q + 2'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      sel_q        <= '0;
      gnt_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      gnt_q        <= gnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end
  assign gnt        = gnt_q;
  assign sel        = sel_q;
  assign ack        = beat ? gnt_q : 4'b0000;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = state_q == GRANT;
endmodule
